// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The op_sub field exists only when SUB_ADD_EN is defined.
interface serial_add_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SUB_ADD_EN
  logic         op_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
`ifdef SUB_ADD_EN
    output op_sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
`ifdef SUB_ADD_EN
    input  op_sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit ripple slice, LSB nibble first.
// Define SUB_ADD_EN to add the op_sub (A - B) mode.
module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  always_comb begin : chain
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             c_out_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W+1:0] base;
  logic [W-1:0]     b_cap;
  logic             c_cap;
  logic [3:0]       slice_sum;
  logic             slice_carry;

`ifdef SUB_ADD_EN
  // Subtraction is A + ~B + 1, so the external carry-in is overridden.
  assign b_cap = bus.op_sub ? ~bus.b : bus.b;
  assign c_cap = bus.op_sub ? 1'b1   : bus.c_in;
`else
  assign b_cap = bus.b;
  assign c_cap = bus.c_in;
`endif

  assign base = {cnt, 2'b00};

  ripple_adder slice (
    .a  (a_q[base +: 4]),
    .b  (b_q[base +: 4]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // cnt saturates on the last nibble so it never wraps inside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= b_cap;
          carry_q <= c_cap;
          cnt     <= '0;
        end
        RUN: begin
          sum_q[base +: 4] <= slice_sum;
          carry_q          <= slice_carry;
          if (cnt == LAST) c_out_q <= slice_carry;
          else             cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-word add sequencer that computes a (4·NIBBLES)-bit sum with one shared 4-bit ripple_adder slice, processing one nibble per clock, LSB first. The carry is held in a flop between nibbles. Operands are captured with a valid/ready handshake and the result is presented with a valid/ready handshake. The block sits between operand producers and result consumers wherever a wide add is needed and area matters more than latency.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4·NIBBLES; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b/c_in (and op_sub) are valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry-in to nibble 0.
- op_sub  input  1  present only with SUB_ADD_EN; 1 = A − B.
- out_valid  output  1  sum/c_out are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- c_out  output  1  carry out of the top nibble (for subtract, 1 = no borrow).

## Operation
- One ripple_adder instance is muxed by nibble index cnt: the slice adds a_q[4cnt+3:4cnt] and b_q slice, with carry-in carry_q.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid: capture a_q ← a, b_q ← b, carry_q ← c_in, cnt ← 0, then go to RUN.
  - RUN: each cycle
    - Write the slice sum into sum_q[4cnt+3:4cnt].
    - carry_q ← slice carry.
    - cnt ← cnt+1.
    - When cnt == NIBBLES−1: go to DONE; the last slice carry goes to c_out.
  - DONE:
    - out_valid = 1; sum/c_out held stable.
    - On out_ready: go to IDLE.
- in_ready is 1 only in IDLE. Inputs are ignored in RUN and DONE.
- No back-to-back overlap: a new operand pair is accepted no earlier than the cycle after DONE exits.
- cnt width is clog2(NIBBLES). cnt resets to 0 on capture and does not wrap during RUN.
- Arithmetic: the result is modulo 2^W. No overflow flag is produced.

## Timing
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - in_ready = 1, out_valid = 0, sum = 0, c_out = 0.
  - Internal a_q, b_q, carry_q and cnt = 0.
- Reset asserted mid-RUN or in DONE:
  - The operation is aborted immediately and the result is discarded.
  - No out_valid appears after reset release.
- Latency: operands are accepted on clock edge T0. out_valid is high from edge T0+NIBBLES until the edge on which out_ready is sampled high.
- Throughput: one operation per NIBBLES+2 cycles when out_ready is held high.
- in_valid with in_ready = 0 has no effect. The producer must hold its data until accepted.
- out_valid, once high, stays high with unchanged sum/c_out until out_ready.
- sum and c_out are registered outputs. They keep the last result after the DONE→IDLE transition until the next result completes.

## Configuration
- SUB_ADD_EN defined:
  - The op_sub port exists and is captured with the operands.
  - When op_sub = 1:
    - b_q is stored as ~b.
    - carry_q is seeded with 1 (c_in is ignored), giving A − B in two's complement.
    - c_out = 1 means A ≥ B, unsigned.
- SUB_ADD_EN undefined:
  - The op_sub port and the inversion logic are absent.
  - The block only adds, using c_in.

## Test plan
All tests use NIBBLES = 4.
- Basic add: a = 0x1234, b = 0x4321, c_in = 0, out_ready = 1 → sum = 0x5555, c_out = 0. out_valid rises 4 cycles after acceptance and lasts 1 cycle; in_ready returns on the next cycle.
- Full carry chain: a = 0xFFFF, b = 0x0001, c_in = 0 → sum = 0x0000, c_out = 1. a = 0x7FFF, b = 0x0000, c_in = 1 → sum = 0x8000, c_out = 0.
- Backpressure: out_ready held low 10 cycles after out_valid:
  - sum and out_valid stay stable throughout.
  - in_ready stays 0; a new in_valid pulse offered during the stall is not captured.
  - Release → IDLE next cycle.
- Reset mid-operation: drop rst_n 2 cycles into RUN → all outputs read 0 asynchronously, in_ready = 1. After release, no out_valid until a new operand pair is accepted.
- Back-to-back with in_valid held high and out_ready = 1: two pairs complete 6 cycles apart, results in order.
- SUB_ADD_EN: 0x0005 − 0x0007 → sum = 0xFFFE, c_out = 0. 0x0009 − 0x0003 → sum = 0x0006, c_out = 1.
